// File: rtl/pipe_mux_nto1.sv
// -----------------------------------------------------------------------------
// pipe_mux_nto1
//
// Registered N-to-1 word multiplexer intended to sit on a pipeline-register
// boundary (operand / forwarding selection). One of INPUTS channels is chosen
// by sel and captured into a single output stage together with the select
// value, a valid flag and an illegal-select flag. There is no combinational
// path from any input to any output.
//
// Per-edge priority: flush > stall > load > idle.
//   flush : q <= FLUSH_VAL, q_valid/sel_err/q_sel cleared
//   stall : every output register holds
//   load  : q_sel <= sel, q_valid <= 1, q <= channel[sel] or FLUSH_VAL when
//           sel >= INPUTS (sel_err <= 1 in that case)
//   idle  : q_valid/sel_err cleared, q and q_sel hold (no toggling on
//           invalid beats)
//
// Parameters:
//   WIDTH     bits per channel and per output word
//   INPUTS    number of channels (2..16)
//   SEL_W     select width, 2**SEL_W >= INPUTS
//   FLUSH_VAL word loaded on reset, flush and illegal select
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_flat   in   packed channels, channel i = in_flat[i*WIDTH +: WIDTH]
//   sel       in   channel select
//   in_valid  in   sel/in_flat are meaningful this cycle
//   stall     in   hold all registered outputs
//   flush     in   invalidate the output stage
//   q         out  registered selected word
//   q_valid   out  q holds a valid selection
//   q_sel     out  select value captured with q
//   sel_err   out  captured select was >= INPUTS (per beat, not sticky)
//   err_cnt   out  (only with PIPE_MUX_ERRCNT_EN) saturating 8-bit count of
//                  illegal-select load beats; survives flush, frozen by stall
//
// Optional feature macro: PIPE_MUX_ERRCNT_EN
// -----------------------------------------------------------------------------
module pipe_mux_nto1 #(
    parameter int               WIDTH     = 32,
    parameter int               INPUTS    = 4,
    parameter int               SEL_W     = 2,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUTS*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic [SEL_W-1:0]        q_sel,
    output logic                    sel_err
`ifdef PIPE_MUX_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    // Elaboration-time parameter sanity checks
    if (INPUTS < 2) begin : g_chk_inputs
        $error("pipe_mux_nto1: INPUTS must be at least 2");
    end
    if ((1 << SEL_W) < INPUTS) begin : g_chk_selw
        $error("pipe_mux_nto1: SEL_W too narrow to address all INPUTS");
    end

    // Channel unpacking with constant-width part-selects
    logic [WIDTH-1:0] w_ch [INPUTS];

    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_unpack
        assign w_ch[gi] = in_flat[gi*WIDTH +: WIDTH];
    end

    // Legal-select detection. When INPUTS fills the whole select space every
    // code is legal, so no comparator is built at all.
    logic w_sel_ok;

    if ((1 << SEL_W) > INPUTS) begin : g_sel_range
        assign w_sel_ok = (sel < SEL_W'(INPUTS));
    end else begin : g_sel_full
        assign w_sel_ok = 1'b1;
    end

    // Word selection: an out-of-range select falls through to FLUSH_VAL, which
    // is exactly what an illegal-select load must capture.
    logic [WIDTH-1:0] w_sel_word;

    always_comb begin
        w_sel_word = FLUSH_VAL;
        for (int i = 0; i < INPUTS; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_word = w_ch[i];
            end
        end
    end

    // ---- stage p1: output register ----
    logic [WIDTH-1:0] r_q_p1;
    logic             r_vld_p1;
    logic [SEL_W-1:0] r_sel_p1;
    logic             r_err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_p1   <= FLUSH_VAL;
            r_vld_p1 <= 1'b0;
            r_sel_p1 <= '0;
            r_err_p1 <= 1'b0;
        end else if (flush) begin
            r_q_p1   <= FLUSH_VAL;
            r_vld_p1 <= 1'b0;
            r_sel_p1 <= '0;
            r_err_p1 <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                r_q_p1   <= w_sel_word;
                r_vld_p1 <= 1'b1;
                r_sel_p1 <= sel;
                r_err_p1 <= ~w_sel_ok;
            end else begin
                // Idle beat: data and select deliberately left untouched
                r_vld_p1 <= 1'b0;
                r_err_p1 <= 1'b0;
            end
        end
    end

    assign q       = r_q_p1;
    assign q_valid = r_vld_p1;
    assign q_sel   = r_sel_p1;
    assign sel_err = r_err_p1;

`ifdef PIPE_MUX_ERRCNT_EN
    // Illegal-select counter. Counts only real load beats, so flush and stall
    // both suppress the increment; flush does not clear it.
    logic [7:0] r_err_cnt;
    logic       w_cnt_inc;

    assign w_cnt_inc = in_valid & ~stall & ~flush & ~w_sel_ok
                     & (r_err_cnt != 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_cnt_inc) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// -----------------------------------------------------------------------------
// Bench for pipe_mux_nto1. Two instances run side by side on shared control:
//   u4 : INPUTS=4, SEL_W=2, FLUSH_VAL=0          (power-of-two channel count)
//   u5 : INPUTS=5, SEL_W=3, FLUSH_VAL=F00DF00D   (illegal selects possible)
// -----------------------------------------------------------------------------
module tb_pipe_mux_nto1;

    localparam logic [31:0] FV4 = 32'h0000_0000;
    localparam logic [31:0] FV5 = 32'hF00D_F00D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [1:0]  sel4;
    logic [2:0]  sel5;
    logic [31:0] ch4 [4];
    logic [31:0] ch5 [8];
    logic [127:0] flat4;
    logic [159:0] flat5;

    logic [31:0] q4, q5;
    logic        qv4, qv5, se4, se5;
    logic [1:0]  qs4;
    logic [2:0]  qs5;
`ifdef PIPE_MUX_ERRCNT_EN
    logic [7:0]  ec4, ec5;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign flat4 = {ch4[3], ch4[2], ch4[1], ch4[0]};
    assign flat5 = {ch5[4], ch5[3], ch5[2], ch5[1], ch5[0]};

    pipe_mux_nto1 #(.WIDTH(32), .INPUTS(4), .SEL_W(2), .FLUSH_VAL(FV4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_flat(flat4), .sel(sel4),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .q(q4), .q_valid(qv4), .q_sel(qs4), .sel_err(se4)
`ifdef PIPE_MUX_ERRCNT_EN
        , .err_cnt(ec4)
`endif
    );

    pipe_mux_nto1 #(.WIDTH(32), .INPUTS(5), .SEL_W(3), .FLUSH_VAL(FV5)) u5 (
        .clk(clk), .rst_n(rst_n), .in_flat(flat5), .sel(sel5),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .q(q5), .q_valid(qv5), .q_sel(qs5), .sel_err(se5)
`ifdef PIPE_MUX_ERRCNT_EN
        , .err_cnt(ec5)
`endif
    );

    // Reference model: state of one output stage plus the error count
    typedef struct {
        logic [31:0] q;
        bit          v;
        int          qs;
        bit          e;
        int          cnt;
    } m_t;

    m_t m4, m5;

    function automatic m_t step(m_t s, int n, logic [31:0] fv, logic [31:0] word,
                                int sel, bit vld, bit st, bit fl);
        m_t r = s;
        if (fl) begin
            r.q = fv; r.v = 0; r.qs = 0; r.e = 0;
        end else if (!st && vld) begin
            r.v  = 1;
            r.qs = sel;
            if (sel < n) begin
                r.q = word; r.e = 0;
            end else begin
                r.q = fv; r.e = 1;
                if (r.cnt < 255) r.cnt = r.cnt + 1;
            end
        end else if (!st) begin
            r.v = 0; r.e = 0;
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m4 = '{q: FV4, v: 0, qs: 0, e: 0, cnt: 0};
        m5 = '{q: FV5, v: 0, qs: 0, e: 0, cnt: 0};
    endtask

    // One clock: advance model with the inputs the DUT samples, then settle
    task automatic tick();
        @(posedge clk);
        m4 = step(m4, 4, FV4, ch4[sel4], int'(sel4), in_valid, stall, flush);
        m5 = step(m5, 5, FV5, ch5[sel5], int'(sel5), in_valid, stall, flush);
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_q4"},  q4,        m4.q);
        chk({tag, "_v4"},  32'(qv4),  32'(m4.v));
        chk({tag, "_s4"},  32'(qs4),  32'(m4.qs));
        chk({tag, "_e4"},  32'(se4),  32'(m4.e));
        chk({tag, "_q5"},  q5,        m5.q);
        chk({tag, "_v5"},  32'(qv5),  32'(m5.v));
        chk({tag, "_s5"},  32'(qs5),  32'(m5.qs));
        chk({tag, "_e5"},  32'(se5),  32'(m5.e));
`ifdef PIPE_MUX_ERRCNT_EN
        chk({tag, "_c4"},  32'(ec4),  32'(m4.cnt));
        chk({tag, "_c5"},  32'(ec5),  32'(m5.cnt));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_fixed_channels();
        ch4[0] = 32'h1111_1111; ch4[1] = 32'h2222_2222;
        ch4[2] = 32'h3333_3333; ch4[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) ch5[i] = ch4[i];
        ch5[4] = 32'hA5A5_A5A5;
        for (int i = 5; i < 8; i++) ch5[i] = 32'h0;
    endtask

    typedef struct {
        bit vld, st, fl;
        int s4, s5;
        logic [31:0] q4; bit v4; int qs4; bit e4;
        logic [31:0] q5; bit v5; int qs5; bit e5;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // vld st fl s4 s5 | q4 v4 qs4 e4 | q5 v5 qs5 e5
        tbl[0]  = '{1,0,0, 3,6, 32'h44444444,1,3,0, FV5,1,6,1};
        tbl[1]  = '{1,0,0, 1,4, 32'h22222222,1,1,0, 32'hA5A5A5A5,1,4,0};
        tbl[2]  = '{1,1,0, 0,0, 32'h22222222,1,1,0, 32'hA5A5A5A5,1,4,0};
        tbl[3]  = '{1,1,0, 0,0, 32'h22222222,1,1,0, 32'hA5A5A5A5,1,4,0};
        tbl[4]  = '{1,1,0, 0,0, 32'h22222222,1,1,0, 32'hA5A5A5A5,1,4,0};
        tbl[5]  = '{1,1,1, 0,0, FV4,0,0,0, FV5,0,0,0};
        tbl[6]  = '{1,0,0, 0,7, 32'h11111111,1,0,0, FV5,1,7,1};
        tbl[7]  = '{0,0,0, 2,2, 32'h11111111,0,0,0, FV5,0,7,0};
        tbl[8]  = '{1,0,0, 2,5, 32'h33333333,1,2,0, FV5,1,5,1};
        tbl[9]  = '{0,1,0, 0,0, 32'h33333333,1,2,0, FV5,1,5,1};
        tbl[10] = '{1,0,1, 3,3, FV4,0,0,0, FV5,0,0,0};
        tbl[11] = '{1,0,0, 3,3, 32'h44444444,1,3,0, 32'h44444444,1,3,0};
        tbl[12] = '{1,0,0, 0,0, 32'h11111111,1,0,0, 32'h11111111,1,0,0};

        in_valid = 0; stall = 0; flush = 0; sel4 = 0; sel5 = 0;
        set_fixed_channels();
        rst_n = 1'b0;
        model_reset();
        #12;

        // Reset values while rst_n is still low
        chk("rst_q4", q4, FV4);
        chk("rst_v4", 32'(qv4), 32'd0);
        chk("rst_s4", 32'(qs4), 32'd0);
        chk("rst_e4", 32'(se4), 32'd0);
        chk("rst_q5", q5, FV5);
        chk("rst_v5", 32'(qv5), 32'd0);
`ifdef PIPE_MUX_ERRCNT_EN
        chk("rst_c5", 32'(ec5), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].vld; stall = tbl[i].st; flush = tbl[i].fl;
            sel4 = 2'(tbl[i].s4);  sel5 = 3'(tbl[i].s5);
            tick();
            chk($sformatf("t%0d_q4", i), q4,       tbl[i].q4);
            chk($sformatf("t%0d_v4", i), 32'(qv4), 32'(tbl[i].v4));
            chk($sformatf("t%0d_s4", i), 32'(qs4), 32'(tbl[i].qs4));
            chk($sformatf("t%0d_e4", i), 32'(se4), 32'(tbl[i].e4));
            chk($sformatf("t%0d_q5", i), q5,       tbl[i].q5);
            chk($sformatf("t%0d_v5", i), 32'(qv5), 32'(tbl[i].v5));
            chk($sformatf("t%0d_s5", i), 32'(qs5), 32'(tbl[i].qs5));
            chk($sformatf("t%0d_e5", i), 32'(se5), 32'(tbl[i].e5));
        end

        // Asynchronous reset in the middle of a cycle
        ch4[2] = 32'hDEAD_BEEF;
        in_valid = 1; stall = 0; flush = 0; sel4 = 2'd2; sel5 = 3'd4;
        tick();
        chk("pre_arst_q4", q4, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q4", q4, FV4);
        chk("arst_v4", 32'(qv4), 32'd0);
        chk("arst_q5", q5, FV5);
        chk("arst_v5", 32'(qv5), 32'd0);
        set_fixed_channels();
        in_valid = 0;
        do_reset();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            sel4     = 2'($urandom);
            sel5     = 3'($urandom);
            for (int i = 0; i < 4; i++) ch4[i] = $urandom;
            for (int i = 0; i < 5; i++) ch5[i] = $urandom;
            tick();
            chk_model("rnd");
        end

`ifdef PIPE_MUX_ERRCNT_EN
        // Counter saturation with one stall beat
        in_valid = 0; stall = 0; flush = 0;
        do_reset();
        in_valid = 1; sel4 = 2'd0; sel5 = 3'd6;
        for (int i = 0; i < 300; i++) begin
            stall = (i == 150);
            tick();
            chk_model("cnt");
            if (i == 150) chk("cnt_stall_hold", 32'(ec5), 32'd150);
        end
        chk("cnt_final", 32'(ec5), 32'd255);
        chk("cnt_final_u4", 32'(ec4), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
